// File: rtl/dm_block_mover.sv
// dm_block_mover: data-memory bus master that moves words without the CPU.
//   copy mode: dst[i] <= src[i] for i = 0..len-1. Each word takes a READ
//              cycle followed by a WRITE cycle.
//   fill mode: dst[i] <= fill_val for i = 0..len-1. Each word takes one
//              WRITE cycle.
// A 16-bit modulo running sum of every written word is kept in sum.
//
// Ports
//   clk, reset      clock; asynchronous active-low reset
//   start           command strobe, only honoured in IDLE
//   mode            0 = copy, 1 = fill
//   src, dst        base addresses (AW-bit, wrap around)
//   len             word count (0 = no memory traffic, just done)
//   fill_val        word written in fill mode
//   busy            high while in READ or WRITE
//   done            one-cycle completion pulse
//   sum             modulo-2^DW sum of the words written by the last command
//   dm_addr/dm_din/dm_we  memory request (all registered)
//   dm_dout         combinational memory read data for dm_addr
module dm_block_mover #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] sum,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic          dm_we,
  input  logic [DW-1:0] dm_dout
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t        state;
  logic          mode_q;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [LW-1:0] len_q;
  logic [DW-1:0] fill_q;
  logic [LW-1:0] idx;
  logic [LW-1:0] idx_nxt;

  assign idx_nxt = idx + LW'(1);

  // All outputs are registered, so every transition loads the bus values
  // that belong to the state being entered. In copy mode dm_din doubles as
  // the hold register: dm_dout is captured into it on the READ->WRITE edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      dm_addr <= '0;
      dm_din  <= '0;
      dm_we   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          dm_we   <= 1'b0;
          dm_addr <= '0;
          dm_din  <= '0;
          if (start) begin
            mode_q <= mode;
            src_q  <= src;
            dst_q  <= dst;
            len_q  <= len;
            fill_q <= fill_val;
            idx    <= '0;
            sum    <= '0;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (!mode) begin
              state   <= READ;
              busy    <= 1'b1;
              dm_addr <= src;
            end else begin
              state   <= WRITE;
              busy    <= 1'b1;
              dm_we   <= 1'b1;
              dm_addr <= dst;
              dm_din  <= fill_val;
            end
          end
        end

        READ: begin
          state   <= WRITE;
          dm_we   <= 1'b1;
          dm_addr <= dst_q + AW'(idx);
          dm_din  <= dm_dout;
        end

        WRITE: begin
          sum <= sum + dm_din;
          idx <= idx_nxt;
          if (idx_nxt == len_q) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            dm_we   <= 1'b0;
            dm_addr <= '0;
            dm_din  <= '0;
          end else if (!mode_q) begin
            state   <= READ;
            dm_we   <= 1'b0;
            dm_addr <= src_q + AW'(idx_nxt);
            dm_din  <= '0;
          end else begin
            dm_addr <= dst_q + AW'(idx_nxt);
            dm_din  <= fill_q;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          dm_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_block_mover.sv
// Testbench for dm_block_mover: behavioural 256x16 memory, reference copy of
// memory, and a scoreboard of expected read addresses and write beats.
module tb_dm_block_mover;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mode;
  logic [7:0]  src;
  logic [7:0]  dst;
  logic [7:0]  len;
  logic [15:0] fill_val;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic [7:0]  dm_addr;
  logic [15:0] dm_din;
  logic        dm_we;
  logic [15:0] dm_dout;

  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];

  logic [23:0] wr_q [$];
  logic [7:0]  rd_q [$];

  int errors = 0;
  int checks = 0;

  dm_block_mover #(.AW(8), .DW(16), .LW(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .fill_val (fill_val),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .dm_addr  (dm_addr),
    .dm_din   (dm_din),
    .dm_we    (dm_we),
    .dm_dout  (dm_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_dout = mem[dm_addr];

  always @(posedge clk) begin
    if (dm_we) mem[dm_addr] <= dm_din;
  end

  task automatic set_mem(input logic [7:0] a, input logic [15:0] v);
    mem[a] <= v;
    ref_mem[a] = v;
  endtask

  task automatic cmp_mem(input string name);
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int a = 0; a < 256; a++) begin
      if (mem[a] !== ref_mem[a]) begin
        bad++;
        if (first < 0) first = a;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s memory: %0d words differ, first at 0x%02h got 0x%04h want 0x%04h",
               name, bad, first, mem[first], ref_mem[first]);
    end
  endtask

  // Issues one command, scoreboards every bus beat, and checks timing,
  // sum and final memory. poke > 0 re-pulses start during that busy cycle.
  task automatic run_cmd(input string name, input logic m, input logic [7:0] s,
                         input logic [7:0] d, input logic [7:0] l,
                         input logic [15:0] fv, input int poke);
    logic [15:0] exp_sum;
    logic [15:0] v;
    logic [7:0]  a;
    logic [23:0] w;
    logic [7:0]  ra;
    int lat, cycle, busy_n, we_n, done_cyc, budget, extra_bad;
    bit got_done;

    exp_sum = '0;
    wr_q.delete();
    rd_q.delete();
    for (int i = 0; i < int'(l); i++) begin
      a = d + 8'(i);
      if (m) v = fv;
      else begin
        v = ref_mem[8'(s + 8'(i))];
        rd_q.push_back(8'(s + 8'(i)));
      end
      wr_q.push_back({a, v});
      ref_mem[a] = v;
      exp_sum = exp_sum + v;
    end
    lat = (l == 0) ? 1 : (m ? int'(l) + 1 : 2 * int'(l) + 1);

    start = 1'b1; mode = m; src = s; dst = d; len = l; fill_val = fv;
    @(posedge clk); #1;
    cycle = 1; busy_n = 0; we_n = 0; done_cyc = -1; got_done = 0;
    budget = 2 * int'(l) + 20;
    while (!got_done && cycle <= budget) begin
      // Scramble command inputs: only latched values may matter.
      start = (cycle == poke);
      mode = 1'($urandom); src = 8'($urandom); dst = 8'($urandom);
      len = 8'($urandom_range(1, 3)); fill_val = 16'($urandom);
      if (busy) busy_n++;
      if (dm_we) begin
        we_n++;
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_write: got addr 0x%02h data 0x%04h, want no write",
                   name, dm_addr, dm_din);
        end else begin
          w = wr_q.pop_front();
          if ({dm_addr, dm_din} !== w) begin
            errors++;
            $display("FAIL %s write_beat: got addr 0x%02h data 0x%04h, want addr 0x%02h data 0x%04h",
                     name, dm_addr, dm_din, w[23:16], w[15:0]);
          end
        end
      end else if (busy) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_read: got addr 0x%02h, want no read", name, dm_addr);
        end else begin
          ra = rd_q.pop_front();
          if (dm_addr !== ra) begin
            errors++;
            $display("FAIL %s read_addr: got 0x%02h want 0x%02h", name, dm_addr, ra);
          end
        end
      end
      if (done) begin
        done_cyc = cycle;
        got_done = 1;
      end else begin
        @(posedge clk); #1;
        cycle++;
      end
    end
    start = 1'b0;

    checks++;
    if (done_cyc != lat) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d want %0d (timeout shows -1)", name, done_cyc, lat);
    end
    checks++;
    if (busy_n != lat - 1) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_n, lat - 1);
    end
    checks++;
    if (we_n != int'(l) || wr_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL %s beat_count: got %0d writes, %0d writes and %0d reads outstanding, want %0d writes",
               name, we_n, wr_q.size(), rd_q.size(), l);
    end
    checks++;
    if (sum !== exp_sum) begin
      errors++;
      $display("FAIL %s sum: got 0x%04h want 0x%04h", name, sum, exp_sum);
    end

    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || dm_we !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b we=%b want 0 0 0", name, done, busy, dm_we);
    end
    checks++;
    if (sum !== exp_sum) begin
      errors++;
      $display("FAIL %s sum_hold: got 0x%04h want 0x%04h", name, sum, exp_sum);
    end

    if (poke > 0) begin
      extra_bad = 0;
      for (int c = 0; c < 12; c++) begin
        if (done || dm_we || busy) extra_bad++;
        @(posedge clk); #1;
      end
      checks++;
      if (extra_bad != 0) begin
        errors++;
        $display("FAIL %s ignored_start: got %0d active cycles after done, want 0", name, extra_bad);
      end
    end
    cmp_mem(name);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill_val = '0;
    for (int a = 0; a < 256; a++) set_mem(8'(a), 16'(a * 16'h0101) ^ 16'h5a5a);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, dm_we} !== 3'b000 || sum !== 16'h0 || dm_addr !== 8'h0 || dm_din !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b we=%b sum=0x%04h addr=0x%02h din=0x%04h, want all 0",
               busy, done, dm_we, sum, dm_addr, dm_din);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, dm_we} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b we=%b, want 0 0 0", busy, done, dm_we);
    end
  endtask

  task automatic test_copy();
    set_mem(8'h00, 16'h00ab);
    set_mem(8'h01, 16'h3c00);
    @(posedge clk); #1;
    run_cmd("copy", 1'b0, 8'h00, 8'h08, 8'd2, 16'h0, 0);
    checks++;
    if (mem[8] !== 16'h00ab || mem[9] !== 16'h3c00 || sum !== 16'h3cab) begin
      errors++;
      $display("FAIL copy_values: got mem8=0x%04h mem9=0x%04h sum=0x%04h want 0x00ab 0x3c00 0x3cab",
               mem[8], mem[9], sum);
    end
  endtask

  task automatic test_fill();
    logic [15:0] m3, m7;
    m3 = mem[3];
    m7 = mem[7];
    run_cmd("fill", 1'b1, 8'h00, 8'h04, 8'd3, 16'h8001, 0);
    checks++;
    if (mem[4] !== 16'h8001 || mem[6] !== 16'h8001 || sum !== 16'h8003 ||
        mem[3] !== m3 || mem[7] !== m7) begin
      errors++;
      $display("FAIL fill_values: got mem4=0x%04h mem6=0x%04h sum=0x%04h want 0x8001 0x8001 0x8003",
               mem[4], mem[6], sum);
    end
  endtask

  task automatic test_wrap();
    set_mem(8'hfe, 16'h1111);
    set_mem(8'hff, 16'h2222);
    set_mem(8'h00, 16'h3333);
    set_mem(8'h01, 16'h4444);
    @(posedge clk); #1;
    run_cmd("wrap", 1'b0, 8'hfe, 8'h10, 8'd4, 16'h0, 0);
    checks++;
    if (mem[16] !== 16'h1111 || mem[17] !== 16'h2222 || mem[18] !== 16'h3333 || mem[19] !== 16'h4444) begin
      errors++;
      $display("FAIL wrap_values: got 0x%04h 0x%04h 0x%04h 0x%04h want 0x1111 0x2222 0x3333 0x4444",
               mem[16], mem[17], mem[18], mem[19]);
    end
  endtask

  task automatic test_len_zero();
    run_cmd("len0", 1'b0, 8'h30, 8'h50, 8'd0, 16'h0, 0);
    checks++;
    if (sum !== 16'h0) begin
      errors++;
      $display("FAIL len0_sum: got 0x%04h want 0x0000", sum);
    end
  endtask

  task automatic test_ignored_start();
    run_cmd("ignored_start", 1'b0, 8'h60, 8'h70, 8'd5, 16'h0, 3);
  endtask

  task automatic test_overlap();
    for (int i = 0; i < 4; i++) set_mem(8'(i), 16'(i + 1));
    @(posedge clk); #1;
    run_cmd("overlap", 1'b0, 8'h00, 8'h01, 8'd3, 16'h0, 0);
    checks++;
    if (mem[0] !== 16'd1 || mem[1] !== 16'd1 || mem[2] !== 16'd1 || mem[3] !== 16'd1 || sum !== 16'd3) begin
      errors++;
      $display("FAIL overlap_values: got %0d %0d %0d %0d sum=%0d want 1 1 1 1 sum=3",
               mem[0], mem[1], mem[2], mem[3], sum);
    end
  endtask

  task automatic test_back_to_back();
    run_cmd("b2b_first", 1'b1, 8'h00, 8'h80, 8'd2, 16'hbeef, 0);
    run_cmd("b2b_second", 1'b0, 8'h80, 8'h90, 8'd2, 16'h0, 0);
  endtask

  task automatic test_reset_mid_copy();
    int bad;
    for (int i = 0; i < 8; i++) set_mem(8'(8'h20 + i), 16'(16'hc000 + i));
    @(posedge clk); #1;
    ref_mem[8'h40] = ref_mem[8'h20];
    ref_mem[8'h41] = ref_mem[8'h21];
    start = 1'b1; mode = 1'b0; src = 8'h20; dst = 8'h40; len = 8'd8; fill_val = '0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    // Cycle 6: third WRITE beat (i = 2) is on the bus.
    checks++;
    if (dm_we !== 1'b1 || dm_addr !== 8'h42) begin
      errors++;
      $display("FAIL midreset_third_write: got we=%b addr=0x%02h want 1 0x42", dm_we, dm_addr);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, dm_we} !== 3'b000 || sum !== 16'h0 || dm_addr !== 8'h0 || dm_din !== 16'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b done=%b we=%b sum=0x%04h addr=0x%02h din=0x%04h, want all 0",
               busy, done, dm_we, sum, dm_addr, dm_din);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done || dm_we || busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midreset_quiet: got %0d active cycles after reset, want 0", bad);
    end
    cmp_mem("midreset");
  endtask

  initial begin
    test_reset();
    test_copy();
    test_fill();
    test_wrap();
    test_len_zero();
    test_ignored_start();
    test_overlap();
    test_back_to_back();
    test_reset_mid_copy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_block_mover.md
Name: dm_block_mover

Overview:
- Bus master for the data-memory port: generates addr/din/we and consumes dout.
- Moves data inside data memory without CPU load/store instructions. Two modes:
  - copy: src block to dst block.
  - fill: dst block written with a constant.
- Accumulates a 16-bit running sum of every word it writes.
- Sits beside the CPU; the top level muxes its dm_* outputs onto the memory port while busy=1.

Parameters:
- AW, 8, data-memory address width (addresses wrap modulo 2^AW).
- DW, 16, data word width.
- LW, 8, length field width (max block 2^LW-1 words).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  one-cycle command strobe, sampled only in IDLE.
- mode  input  1  0 = copy, 1 = fill; latched on accepted start.
- src  input  AW  copy source base address; latched on accepted start.
- dst  input  AW  destination base address; latched on accepted start.
- len  input  LW  word count; latched on accepted start.
- fill_val  input  DW  fill word; latched on accepted start.
- busy  output  1  high in READ and WRITE states.
- done  output  1  one-cycle completion pulse.
- sum  output  DW  modulo-2^DW sum of all words written by the last/current command.
- dm_addr  output  AW  memory address.
- dm_din  output  DW  memory write data.
- dm_we  output  1  memory write enable.
- dm_dout  input  DW  memory read data; combinational, valid in the same cycle as dm_addr.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, dm_addr=0, dm_din=0, dm_we=0.
  - Counters and latched command fields are cleared.
- Reset asserted mid-command aborts the command immediately. No further writes occur, and no done pulse is produced.
- States are IDLE, READ, WRITE, DONE.
- IDLE:
  - dm_we=0, dm_addr=0, dm_din=0.
  - On start=1, latch mode/src/dst/len/fill_val, clear index i and sum, then branch:
    - len=0: go to DONE.
    - mode=0: go to READ.
    - mode=1: go to WRITE.
  - With start=0, stay in IDLE.
- READ (copy only):
  - Drive dm_addr=src+i, dm_we=0.
  - Capture dm_dout into a hold register at the clock edge.
  - Go to WRITE.
- WRITE:
  - Drive dm_addr=dst+i, dm_we=1.
  - dm_din = hold register (copy) or fill_val (fill).
  - At the clock edge: sum <= sum+dm_din (truncated to DW), i <= i+1.
  - If i+1==len, go to DONE. Otherwise go to READ (copy) or stay in WRITE (fill).
- DONE: done=1 for exactly one cycle, dm_we=0, busy=0, then IDLE.
- Latency, counted from the clock edge that accepts start:
  - Copy: busy for 2*len cycles; done asserted during cycle 2*len+1.
  - Fill: busy for len cycles; done during cycle len+1.
  - len=0: done during cycle 1, and no memory access occurs.
- start while busy or in DONE is ignored; no queuing.
- Command inputs may change freely after acceptance; only the latched values are used.
- Address arithmetic is AW-bit modulo:
  - src+i and dst+i wrap from 2^AW-1 to 0.
  - The sum ignores carries beyond DW bits.
- Overlapping copy regions are processed strictly ascending (i=0 first) and word by word.
  - When dst>src and the regions overlap, already-written words are re-read; this is the defined behaviour.
  - When dst==src, the copy rewrites each word with its own value.
- dm_we is never asserted outside WRITE. Each dm_we cycle is one word.
- sum holds its value after DONE until the next accepted start or reset.
- A back-to-back start in the IDLE cycle immediately following DONE is accepted.

Test Plan:
- Reset, then copy: mem[0]=0x00ab, mem[1]=0x3c00; start mode=0 src=0 dst=8 len=2.
  - mem[8]=0x00ab, mem[9]=0x3c00, sum=0x3cab.
  - done pulses in cycle 5 (one cycle wide); busy high in cycles 1-4; dm_we high exactly 2 cycles.
- Fill: mode=1 dst=4 len=3 fill_val=0x8001.
  - mem[4..6]=0x8001, sum=0x8003 (overflow truncated); done in cycle 4; mem[3] and mem[7] unchanged.
- Wrap: copy src=0xFE dst=0x10 len=4.
  - Reads addresses 0xFE,0xFF,0x00,0x01; writes 0x10-0x13 with those values in order.
- len=0 and ignored start:
  - start mode=0 len=0: no dm_we, done in cycle 1, sum=0.
  - start pulsed again while busy in a len=5 copy: that start is ignored and only one done occurs.
- Overlap: mem[0..3]=1,2,3,4; copy src=0 dst=1 len=3.
  - mem[0..3]=1,1,1,1, sum=3.
- Async reset mid-copy: drive reset=0 during the 3rd WRITE of a len=8 copy, between clock edges.
  - Outputs go to reset values immediately and no done pulse occurs.
  - Only mem[dst..dst+1] are modified; mem[dst+2] may or may not be written, depending on whether reset asserted before that cycle's clock edge.
